// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared mode/state encodings and sizing helper for the mux_scan block.
`default_nettype none

package mux_scan_pkg;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic int dwell_width(input int dwell);
    return $clog2(dwell + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_scan_ctr.sv
// mux_scan_ctr: dwell and channel counters for SCAN mode, plus the registered WRAP pulse.
`default_nettype none

module mux_scan_ctr
  import mux_scan_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             LOAD,
  input  logic             ACTIVE,
  input  logic [SEL_W-1:0] LOAD_VAL,
  output logic [SEL_W-1:0] CH,
  output logic             WRAP
);

  localparam int DW_W = dwell_width(DWELL);
  localparam logic [SEL_W-1:0] LAST_CH   = SEL_W'(CHANNELS - 1);
  localparam logic [DW_W-1:0]  DWELL_MAX = DW_W'(DWELL);

  logic [SEL_W-1:0] ch_q, ch_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    ch_d    = ch_q;
    dwell_d = dwell_q;
    wrap_d  = 1'b0;
    if (EN) begin
      if (LOAD) begin
        ch_d    = LOAD_VAL;
        dwell_d = DW_W'(1);
      end else if (ACTIVE) begin
        if (dwell_q == DWELL_MAX) begin
          dwell_d = DW_W'(1);
          if (ch_q == LAST_CH) begin
            ch_d   = '0;
            wrap_d = 1'b1;
          end else begin
            ch_d = ch_q + SEL_W'(1);
          end
        end else begin
          dwell_d = dwell_q + DW_W'(1);
        end
      end else begin
        dwell_d = '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ch_q    <= '0;
      dwell_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      ch_q    <= ch_d;
      dwell_q <= dwell_d;
      wrap_q  <= wrap_d;
    end
  end

  // CH is the channel that will be current after this edge, so the top can register its word now
  assign CH   = ch_d;
  assign WRAP = wrap_q;

endmodule

`default_nettype wire

// File: rtl/mux_scan.sv
// mux_scan: registered N-channel word multiplexer with MANUAL select and timed SCAN modes.
`default_nettype none

module mux_scan
  import mux_scan_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 1
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [CHANNELS*WIDTH-1:0] X,
  input  logic [SEL_W-1:0]          S,
  input  logic                      MODE,
  input  logic                      EN,
  output logic [WIDTH-1:0]          Y,
  output logic [SEL_W-1:0]          CH,
  output logic                      VALID,
  output logic                      WRAP
);

  localparam int XW    = CHANNELS * WIDTH;
  localparam int OFF_W = $clog2(XW);
  localparam logic [SEL_W:0] NUM_CH = (SEL_W + 1)'(CHANNELS);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic             valid_q, valid_d;

  logic             s_ok;
  logic [SEL_W-1:0] start_ch;
  logic [SEL_W-1:0] scan_ch;
  logic [SEL_W-1:0] sel;
  logic [OFF_W-1:0] off;
  logic [WIDTH-1:0] word;
  logic             load;
  logic             active;

  assign s_ok     = ({1'b0, S} < NUM_CH);
  assign start_ch = s_ok ? S : '0;
  assign load     = EN && (state_q == ST_MANUAL) && (MODE == MODE_SCAN);
  assign active   = EN && (state_q == ST_SCAN) && (MODE == MODE_SCAN);

  mux_scan_ctr #(
    .CHANNELS(CHANNELS),
    .SEL_W   (SEL_W),
    .DWELL   (DWELL)
  ) u_ctr (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .EN      (EN),
    .LOAD    (load),
    .ACTIVE  (active),
    .LOAD_VAL(start_ch),
    .CH      (scan_ch),
    .WRAP    (WRAP)
  );

  // Out-of-range selects may alias after truncation; they are masked to zero below
  assign sel  = (MODE == MODE_SCAN) ? scan_ch : S;
  assign off  = OFF_W'(sel) * OFF_W'(WIDTH);
  assign word = X[off +: WIDTH];

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    if (EN) begin
      state_d = state_e'(MODE);
      ch_d    = sel;
      if (MODE == MODE_SCAN) begin
        y_d     = word;
        valid_d = 1'b1;
      end else begin
        y_d     = s_ok ? word : '0;
        valid_d = s_ok;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_MANUAL;
      y_q     <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
    end
  end

  assign Y     = y_q;
  assign CH    = ch_q;
  assign VALID = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan.sv
// tb_mux_scan: randomized scoreboard bench for mux_scan against a position-based scan model.
`default_nettype none

module tb_mux_scan;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 3;
  localparam int SEL_W    = 2;
  localparam int DWELL    = 2;
  localparam int XW       = CHANNELS * WIDTH;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic [XW-1:0]    X = '0;
  logic [SEL_W-1:0] S = '0;
  logic             MODE = 1'b0;
  logic             EN = 1'b0;
  logic [WIDTH-1:0] Y;
  logic [SEL_W-1:0] CH;
  logic             VALID;
  logic             WRAP;

  mux_scan #(
    .WIDTH   (WIDTH),
    .CHANNELS(CHANNELS),
    .SEL_W   (SEL_W),
    .DWELL   (DWELL)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .X    (X),
    .S    (S),
    .MODE (MODE),
    .EN   (EN),
    .Y    (Y),
    .CH   (CH),
    .VALID(VALID),
    .WRAP (WRAP)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic [SEL_W-1:0] ch;
    logic             v;
    logic             w;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference: scan position is (entry channel + elapsed active cycles / DWELL) mod CHANNELS
  bit   m_scan = 1'b0;
  int   m_start = 0;
  int   m_k = 0;
  exp_t m_out = '0;

  function automatic logic [WIDTH-1:0] word_of(input logic [XW-1:0] x, input int k);
    return x[k*WIDTH +: WIDTH];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model(input logic [XW-1:0] x, input logic [SEL_W-1:0] s,
                       input logic mode, input logic en);
    int ch;
    m_out.w = 1'b0;
    if (en) begin
      if (!mode) begin
        m_scan   = 1'b0;
        m_out.ch = s;
        if (int'(s) < CHANNELS) begin
          m_out.y = word_of(x, int'(s));
          m_out.v = 1'b1;
        end else begin
          m_out.y = '0;
          m_out.v = 1'b0;
        end
      end else begin
        if (!m_scan) begin
          m_scan  = 1'b1;
          m_start = (int'(s) < CHANNELS) ? int'(s) : 0;
          m_k     = 0;
        end else begin
          m_k++;
        end
        ch       = (m_start + m_k / DWELL) % CHANNELS;
        m_out.w  = (m_k > 0) && (m_k % DWELL == 0) && (ch == 0);
        m_out.ch = SEL_W'(ch);
        m_out.y  = word_of(x, ch);
        m_out.v  = 1'b1;
      end
    end
  endtask

  task automatic step(input logic [XW-1:0] x, input logic [SEL_W-1:0] s,
                      input logic mode, input logic en);
    X    = x;
    S    = s;
    MODE = mode;
    EN   = en;
    model(x, s, mode, en);
    @(posedge CLK);
    exp_q.push_back(m_out);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_Y"},     32'(Y),     32'd0);
    chk({tag, "_CH"},    32'(CH),    32'd0);
    chk({tag, "_VALID"}, 32'(VALID), 32'd0);
    chk({tag, "_WRAP"},  32'(WRAP),  32'd0);
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("Y",     32'(Y),     32'(mon_e.y));
      chk("CH",    32'(CH),    32'(mon_e.ch));
      chk("VALID", 32'(VALID), 32'(mon_e.v));
      chk("WRAP",  32'(WRAP),  32'(mon_e.w));
    end
  end

  logic [XW-1:0] xv;
  logic          mode_r;

  initial begin
    #7;
    chk_zero("por");
    #5 RST_N = 1'b1;
    @(posedge CLK);
    #1;

    xv = {8'hC3, 8'hB2, 8'hA1};
    for (int s = 0; s < 3; s++) step(xv, SEL_W'(s), 1'b0, 1'b1);
    step(xv, 2'd3, 1'b0, 1'b1);
    step(xv, 2'd2, 1'b0, 1'b1);

    step(xv, 2'd2, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(XW'($urandom), 2'($urandom), 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(XW'($urandom), 2'($urandom), 1'($urandom), 1'b0);
    for (int i = 0; i < 5; i++) step(XW'($urandom), 2'($urandom), 1'b1, 1'b1);
    step(xv, 2'd3, 1'b0, 1'b1);
    step(xv, 2'd1, 1'b0, 1'b1);
    step(xv, 2'd3, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(xv, 2'd0, 1'b1, 1'b1);

    mode_r = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) mode_r = ~mode_r;
      step(XW'($urandom), 2'($urandom), mode_r, ($urandom_range(0, 9) != 0));
    end

    step(xv, 2'd1, 1'b0, 1'b1);
    step(xv, 2'd1, 1'b1, 1'b1);
    step(xv, 2'd0, 1'b1, 1'b1);
    step(xv, 2'd0, 1'b1, 1'b1);
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    chk_zero("rst_async");
    EN = 1'b0;
    @(posedge CLK);
    #1;
    chk_zero("rst_hold");
    #2;
    RST_N  = 1'b1;
    m_scan = 1'b0;
    m_out  = '0;
    @(posedge CLK);
    #1;
    step(xv, 2'd0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) step(xv, 2'd0, 1'b1, 1'b1);
    step(xv, 2'd2, 1'b0, 1'b1);

    @(negedge CLK);
    #2;
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
